// File: rtl/nubus_pkg.sv
// Shared types and constants for the NuBus master sequencer and its arbitration helper.
package nubus_pkg;

    localparam int ID_W = 4;

    localparam logic [ID_W-1:0] ARBN_RST   = '1;
    localparam logic [1:0]      TM_RST     = 2'b11;
    localparam logic [1:0]      STATUS_RST = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        LHOLD = 3'd4,
        ATTN  = 3'd5
    } state_t;

    typedef struct packed {
        logic arbcy;
        logic adrcy;
        logic dtacy;
        logic owner;
        logic locked;
    } phase_t;

    // Phase flags for the state being entered; lk is the latched lock request.
    function automatic phase_t phase_flags(input state_t s, input logic lk);
        phase_t p;
        p = '0;
        case (s)
            ARB:     p = '{arbcy: 1'b1, adrcy: 1'b0, dtacy: 1'b0, owner: 1'b0, locked: lk};
            ADDR:    p = '{arbcy: 1'b1, adrcy: 1'b1, dtacy: 1'b0, owner: 1'b1, locked: lk};
            DATA:    p = '{arbcy: lk,   adrcy: 1'b0, dtacy: 1'b1, owner: 1'b1, locked: lk};
            LHOLD:   p = '{arbcy: 1'b1, adrcy: 1'b0, dtacy: 1'b0, owner: 1'b1, locked: 1'b1};
            ATTN:    p = '{arbcy: 1'b1, adrcy: 1'b0, dtacy: 1'b0, owner: 1'b1, locked: 1'b0};
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/nubus_arb_logic.sv
// Combinational NuBus distributed arbitration: per-bit drive/withdraw and the win test.
module nubus_arb_logic
    import nubus_pkg::*;
(
    input  logic [ID_W-1:0] idn,
    input  logic [ID_W-1:0] arbn,
    output logic [ID_W-1:0] driven,
    output logic            win
);

    logic [ID_W-1:0] a;
    logic [ID_W-1:0] d;
    logic [ID_W-1:0] lost;

    assign a = ~arbn;
    assign d = ~idn;

    // A bit withdraws once any higher line is asserted where our ID has a zero.
    always_comb begin
        lost = '0;
        for (int i = 0; i < ID_W; i++) begin
            for (int j = i + 1; j < ID_W; j++) begin
                lost[i] = lost[i] | (a[j] & ~d[j]);
            end
        end
    end

    assign driven = ~(d & ~lost);
    assign win    = (arbn == idn);

endmodule

// File: rtl/nubus_master.sv
// Master-side NuBus sequencer: arbitrates for the bus and steps ARB/ADDR/DATA/LHOLD/ATTN
// phases, producing phase flags for nubus_driver and completion status for the local side.
module nubus_master
    import nubus_pkg::*;
#(
    parameter int ARB_SETTLE = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic            nub_clk,
    input  logic            nub_reset,
    input  logic [ID_W-1:0] nub_idn_i,
    input  logic [ID_W-1:0] nub_arbn_i,
    input  logic            nub_rqstn_i,
    input  logic            nub_startn_i,
    input  logic            nub_ackn_i,
    input  logic            nub_tm1n_i,
    input  logic            nub_tm0n_i,
    // Local handshake: cpu_req_i is held until cpu_done_o pulses; cpu_busy_o covers accept..IDLE.
    input  logic            cpu_req_i,
    input  logic            cpu_lock_i,
    input  logic            cpu_tm1n_i,
    input  logic            cpu_tm0n_i,
    output logic            cpu_busy_o,
    output logic            cpu_done_o,
    output logic [1:0]      cpu_status_o,
    output logic            cpu_timeout_o,
    output logic            mst_arbcy,
    output logic            mst_adrcy,
    output logic            mst_dtacy,
    output logic            mst_owner,
    output logic            mst_locked,
    output logic            mst_tm1n,
    output logic            mst_tm0n,
    output logic [ID_W-1:0] nub_arbn_o,
    output logic            nub_arboe_o,
    output state_t          dbg_state
);

    localparam logic [7:0] SETTLE_LAST  = 8'(ARB_SETTLE - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic            lk, lk_nx;
    logic            bus_busy;
    logic            lost_wait;
    logic [7:0]      settle_cnt;
    logic [7:0]      tmo_cnt;
    logic [ID_W-1:0] arb_driven;
    logic            arb_win;
    logic            ack, settled, judge_ok, to_hit;
    logic            accept, relatch, data_end;
    phase_t          flags_nx;

    nubus_arb_logic u_arb (
        .idn    (nub_idn_i),
        .arbn   (nub_arbn_i),
        .driven (arb_driven),
        .win    (arb_win)
    );

    assign ack      = ~nub_ackn_i;
    assign settled  = (settle_cnt >= SETTLE_LAST);
    assign judge_ok = settled && !lost_wait && arb_win && !bus_busy;
    assign to_hit   = (tmo_cnt == TIMEOUT_LAST);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        lk_nx    = lk;
        case (state)
            IDLE: begin
                if (cpu_req_i && nub_rqstn_i) begin
                    state_nx = ARB;
                    lk_nx    = cpu_lock_i;
                end
            end
            ARB:   if (judge_ok) state_nx = ADDR;
            ADDR:  state_nx = DATA;
            DATA:  if (ack || to_hit) state_nx = lk ? LHOLD : IDLE;
            LHOLD: begin
                if (!cpu_lock_i)    state_nx = ATTN;
                else if (cpu_req_i) state_nx = ADDR;
            end
            ATTN: begin
                state_nx = IDLE;
                lk_nx    = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                lk_nx    = 1'b0;
            end
        endcase
    end

    assign accept   = (state == IDLE)  && (state_nx == ARB);
    assign relatch  = (state == LHOLD) && (state_nx == ADDR);
    assign data_end = (state == DATA)  && (ack || to_hit);
    assign flags_nx = phase_flags(state_nx, lk_nx);

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state         <= IDLE;
            lk            <= 1'b0;
            bus_busy      <= 1'b0;
            lost_wait     <= 1'b0;
            settle_cnt    <= '0;
            tmo_cnt       <= '0;
            cpu_busy_o    <= 1'b0;
            cpu_done_o    <= 1'b0;
            cpu_status_o  <= STATUS_RST;
            cpu_timeout_o <= 1'b0;
            mst_arbcy     <= 1'b0;
            mst_adrcy     <= 1'b0;
            mst_dtacy     <= 1'b0;
            mst_owner     <= 1'b0;
            mst_locked    <= 1'b0;
            {mst_tm1n, mst_tm0n} <= TM_RST;
            nub_arbn_o    <= ARBN_RST;
            nub_arboe_o   <= 1'b0;
        end else begin
            state      <= state_nx;
            lk         <= lk_nx;
            cpu_busy_o <= (state_nx != IDLE);
            {mst_arbcy, mst_adrcy, mst_dtacy, mst_owner, mst_locked} <= flags_nx;

            if (state_nx == IDLE)        {mst_tm1n, mst_tm0n} <= TM_RST;
            else if (accept || relatch)  {mst_tm1n, mst_tm0n} <= {cpu_tm1n_i, cpu_tm0n_i};

            nub_arboe_o <= (state_nx == ARB);
            nub_arbn_o  <= (state_nx == ARB) ? arb_driven : ARBN_RST;

            if (ack)                bus_busy <= 1'b0;
            else if (!nub_startn_i) bus_busy <= 1'b1;

            // After a loss, stop judging until another master's ACK restarts the settle window.
            if (state != ARB || state_nx != ARB) begin
                settle_cnt <= '0;
                lost_wait  <= 1'b0;
            end else if (lost_wait) begin
                if (ack) begin
                    settle_cnt <= '0;
                    lost_wait  <= 1'b0;
                end
            end else if (!settled) begin
                settle_cnt <= settle_cnt + 8'd1;
            end else if (!arb_win) begin
                lost_wait <= 1'b1;
            end

            if (state == DATA) tmo_cnt <= tmo_cnt + 8'd1;
            else               tmo_cnt <= '0;

            cpu_done_o    <= data_end;
            cpu_timeout_o <= data_end && !ack;
            if (data_end) cpu_status_o <= ack ? {nub_tm1n_i, nub_tm0n_i} : 2'b11;
        end
    end

endmodule

// File: tb/tb_nubus_master.sv
// Directed bench for nubus_master: arbitration, fairness, timeout, locked sequences and reset.
module tb_nubus_master;
    import nubus_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      idn = 4'b1100;
    logic [3:0]      other_arbn = 4'hF;
    logic            rqstn = 1'b1, startn = 1'b1, ackn = 1'b1;
    logic            btm1n = 1'b1, btm0n = 1'b1;
    logic            req = 1'b0, lock = 1'b0, ctm1n = 1'b1, ctm0n = 1'b1;
    logic            busy, done, tmo;
    logic [1:0]      status;
    logic            arbcy, adrcy, dtacy, owner, locked, tm1n, tm0n;
    logic [3:0]      arbn_o, arbn_i;
    logic            arboe;
    state_t          dbg_state;

    int checks = 0;
    int errors = 0;

    // Wired-OR (active-low AND) of the competing card and our own ARB drive.
    assign arbn_i = other_arbn & (arboe ? arbn_o : 4'hF);

    always #5 clk = ~clk;

    nubus_master dut (
        .nub_clk(clk), .nub_reset(rst), .nub_idn_i(idn), .nub_arbn_i(arbn_i),
        .nub_rqstn_i(rqstn), .nub_startn_i(startn), .nub_ackn_i(ackn),
        .nub_tm1n_i(btm1n), .nub_tm0n_i(btm0n),
        .cpu_req_i(req), .cpu_lock_i(lock), .cpu_tm1n_i(ctm1n), .cpu_tm0n_i(ctm0n),
        .cpu_busy_o(busy), .cpu_done_o(done), .cpu_status_o(status), .cpu_timeout_o(tmo),
        .mst_arbcy(arbcy), .mst_adrcy(adrcy), .mst_dtacy(dtacy), .mst_owner(owner),
        .mst_locked(locked), .mst_tm1n(tm1n), .mst_tm0n(tm0n),
        .nub_arbn_o(arbn_o), .nub_arboe_o(arboe), .dbg_state(dbg_state)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected phase vector order: {arbcy, adrcy, dtacy, owner, locked}
    task automatic chk_ph(input string tag, input logic [4:0] exp);
        chk(tag, {3'b0, arbcy, adrcy, dtacy, owner, locked}, {3'b0, exp});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_ph({tag, "_ph"}, 5'b00000);
        chk({tag, "_busy_done_tmo"}, {5'b0, busy, done, tmo}, 8'h00);
        chk({tag, "_status"}, {6'b0, status}, 8'h03);
        chk({tag, "_tm"}, {6'b0, tm1n, tm0n}, 8'h03);
        chk({tag, "_arb"}, {3'b0, arboe, arbn_o}, 8'h0F);
    endtask

    initial begin
        // Reset
        tick(2);
        chk_reset_vals("rst");
        rst = 1'b0;

        // Idle bus: ARB 2 clocks, ADDR 1 clock, ACK after 3 DATA clocks
        req = 1'b1; ctm1n = 1'b1; ctm0n = 1'b0;
        tick(1);
        chk_ph("t1_arb1", 5'b10000);
        chk("t1_busy", {7'b0, busy}, 8'h01);
        chk("t1_tm", {6'b0, tm1n, tm0n}, 8'h02);
        chk("t1_arbdrv", {3'b0, arboe, arbn_o}, 8'h1C);
        tick(1);
        chk_ph("t1_arb2", 5'b10000);
        tick(1);
        chk_ph("t1_addr", 5'b11010);
        chk("t1_addr_oe", {7'b0, arboe}, 8'h00);
        tick(1);
        chk_ph("t1_data1", 5'b00110);
        tick(2);
        chk_ph("t1_data3", 5'b00110);
        ackn = 1'b0; btm1n = 1'b0; btm0n = 1'b0;
        tick(1);
        chk("t1_done", {6'b0, done, tmo}, 8'h02);
        chk("t1_status", {6'b0, status}, 8'h00);
        chk_ph("t1_idle", 5'b00000);
        chk("t1_tm_idle", {6'b0, tm1n, tm0n}, 8'h03);
        ackn = 1'b1; btm1n = 1'b1; btm0n = 1'b1; req = 1'b0;
        tick(1);
        chk("t1_done_pulse", {7'b0, done}, 8'h00);

        // Fairness: RQST low holds off arbitration
        rqstn = 1'b0; req = 1'b1; ctm1n = 1'b1; ctm0n = 1'b1;
        tick(3);
        chk_ph("fair_hold", 5'b00000);
        chk("fair_busy", {7'b0, busy}, 8'h00);
        rqstn = 1'b1;
        tick(1);
        chk_ph("fair_arb", 5'b10000);
        tick(2);
        chk_ph("fair_addr", 5'b11010);
        tick(1);
        ackn = 1'b0; btm1n = 1'b0; btm0n = 1'b1;
        tick(1);
        chk("fair_done", {5'b0, done, status}, 8'h05);
        ackn = 1'b1; btm1n = 1'b1; req = 1'b0;
        tick(1);

        // Competing master with higher ID: lose, wait for its ACK, then win
        other_arbn = 4'b0011; req = 1'b1;
        tick(1);
        chk_ph("cmp_arb", 5'b10000);
        chk("cmp_withdraw", {3'b0, arboe, arbn_o}, 8'h1F);
        tick(5);
        chk_ph("cmp_lost", 5'b10000);
        startn = 1'b0;
        tick(1);
        startn = 1'b1; other_arbn = 4'hF;
        tick(2);
        chk_ph("cmp_wait", 5'b10000);
        ackn = 1'b0;
        tick(1);
        ackn = 1'b1;
        chk_ph("cmp_rearb1", 5'b10000);
        tick(1);
        chk_ph("cmp_rearb2", 5'b10000);
        chk("cmp_drive", {4'b0, arbn_o}, 8'h0C);
        tick(1);
        chk_ph("cmp_addr", 5'b11010);
        tick(1);
        ackn = 1'b0; btm1n = 1'b1; btm0n = 1'b0;
        tick(1);
        chk("cmp_done", {5'b0, done, status}, 8'h06);
        ackn = 1'b1; btm0n = 1'b1; req = 1'b0;
        tick(1);

        // Timeout with no ACK
        req = 1'b1; ctm1n = 1'b0; ctm0n = 1'b0;
        tick(4);
        chk_ph("to_data", 5'b00110);
        tick(254);
        chk("to_before", {6'b0, done, dtacy}, 8'h01);
        tick(1);
        chk("to_done", {5'b0, done, tmo, dtacy}, 8'h06);
        chk("to_status", {6'b0, status}, 8'h03);
        req = 1'b0;
        tick(1);

        // ACK on the timeout clock wins
        req = 1'b1;
        tick(4);
        tick(254);
        ackn = 1'b0; btm1n = 1'b0; btm0n = 1'b1;
        tick(1);
        chk("toack_done", {6'b0, done, tmo}, 8'h02);
        chk("toack_status", {6'b0, status}, 8'h01);
        ackn = 1'b1; btm1n = 1'b1; req = 1'b0;
        tick(1);

        // Locked sequence: two transfers then NULL-ATTN
        req = 1'b1; lock = 1'b1; ctm1n = 1'b1; ctm0n = 1'b0;
        tick(1);
        chk_ph("lk_arb", 5'b10001);
        tick(2);
        chk_ph("lk_addr1", 5'b11011);
        tick(1);
        chk_ph("lk_data1", 5'b10111);
        ackn = 1'b0; btm1n = 1'b0; btm0n = 1'b0;
        tick(1);
        chk_ph("lk_hold1", 5'b10011);
        chk("lk_done1", {7'b0, done}, 8'h01);
        ackn = 1'b1; ctm1n = 1'b0; ctm0n = 1'b1;
        tick(1);
        chk_ph("lk_addr2", 5'b11011);
        chk("lk_relatch", {6'b0, tm1n, tm0n}, 8'h01);
        tick(1);
        chk_ph("lk_data2", 5'b10111);
        ackn = 1'b0;
        tick(1);
        chk_ph("lk_hold2", 5'b10011);
        ackn = 1'b1; lock = 1'b0;
        tick(1);
        chk_ph("lk_attn", 5'b10010);
        req = 1'b0;
        tick(1);
        chk_ph("lk_idle", 5'b00000);
        chk("lk_busy", {7'b0, busy}, 8'h00);

        // Reset during DATA releases everything immediately
        req = 1'b1; ctm1n = 1'b0; ctm0n = 1'b0;
        tick(4);
        chk_ph("rd_data", 5'b00110);
        rst = 1'b1;
        #2;
        chk_reset_vals("rd_async");
        tick(1);
        rst = 1'b0;
        tick(1);
        chk_ph("rd_arb", 5'b10000);
        tick(2);
        chk_ph("rd_addr", 5'b11010);
        tick(1);
        ackn = 1'b0; btm1n = 1'b1; btm0n = 1'b0;
        tick(1);
        chk("rd_done", {5'b0, done, status}, 8'h06);
        ackn = 1'b1; req = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
